// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and state type for the trap sequencer.
// Holds the SYSTEM instruction encodings, the mcause codes and the FSM state enum.
package trap_pkg;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAP   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_MRET   = 2'd3
  } trap_state_t;
endpackage

// File: rtl/trap_ctrl_timer.sv
// machine_timer: free-running mtime plus writable mtimecmp and the pending compare.
// Ports: clk, rst_n (async, active-low); cmp_wen/cmp_wdata load mtimecmp;
// mtime is the counter value; timer_pending = mtime >= mtimecmp (unsigned).
module machine_timer #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] MTIMECMP_RST = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmp_wen,
  input  logic [XLEN-1:0] cmp_wdata,
  output logic [XLEN-1:0] mtime,
  output logic            timer_pending
);
  logic [XLEN-1:0] mtimecmp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
    end else begin
      mtime <= mtime + 1'b1;
      if (cmp_wen) mtimecmp <= cmp_wdata;
    end
  end
  // compares against the registered mtimecmp, so a write lands only after the edge
  assign timer_pending = mtime >= mtimecmp;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer feeding the CSR file and redirecting fetch.
// Ports: clk, rst_n (async, active-low); retiring inst_valid/instruction/pc;
// mtvec/mepc/mie from the CSR file; ext_irq level interrupt; cmp_wen/cmp_wdata
// mtimecmp write; trap_valid/irq_no/trap_epc cause+EPC capture strobe;
// redirect_valid/redirect_pc fetch redirect; stall holds the core; mtime timer value.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] MTIMECMP_RST = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            mie,
  input  logic            ext_irq,
  input  logic            cmp_wen,
  input  logic [XLEN-1:0] cmp_wdata,
  output logic            trap_valid,
  output logic [XLEN-1:0] irq_no,
  output logic [XLEN-1:0] trap_epc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall,
  output logic [XLEN-1:0] mtime
);
  // interrupt causes keep their interrupt flag in the MSB whatever XLEN is
  localparam logic [XLEN-1:0] C_ECALL  = XLEN'(CAUSE_ECALL);
  localparam logic [XLEN-1:0] C_EBREAK = XLEN'(CAUSE_EBREAK);
  localparam logic [XLEN-1:0] C_MTI    = {CAUSE_MTI[31], (XLEN-1)'(CAUSE_MTI[30:0])};
  localparam logic [XLEN-1:0] C_MEI    = {CAUSE_MEI[31], (XLEN-1)'(CAUSE_MEI[30:0])};
  trap_state_t     state;
  logic            timer_pending;
  logic            is_ecall, is_ebreak, is_mret, irq_tmr, irq_ext, trap_evt;
  logic [XLEN-1:0] trap_cause, cause_q, epc_q;
  machine_timer #(.XLEN(XLEN), .MTIMECMP_RST(MTIMECMP_RST)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .cmp_wen(cmp_wen),
    .cmp_wdata(cmp_wdata),
    .mtime(mtime),
    .timer_pending(timer_pending)
  );
  always_comb begin
    is_ecall   = inst_valid && instruction == INST_ECALL;
    is_ebreak  = inst_valid && instruction == INST_EBREAK;
    is_mret    = inst_valid && instruction == INST_MRET;
    irq_tmr    = mie && timer_pending;
    irq_ext    = mie && ext_irq;
    trap_evt   = is_ecall || is_ebreak || irq_tmr || irq_ext;
    trap_cause = is_ecall ? C_ECALL : is_ebreak ? C_EBREAK : irq_tmr ? C_MTI : C_MEI;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state <= state == ST_TRAP ? ST_VECTOR :
               state != ST_IDLE ? ST_IDLE :
               trap_evt         ? ST_TRAP :
               is_mret          ? ST_MRET : ST_IDLE;
      // for interrupts pc is the pre-empted instruction, which the core squashes
      if (state == ST_IDLE && trap_evt) begin
        cause_q <= trap_cause;
        epc_q   <= pc;
      end
    end
  end
  always_comb begin
    trap_valid     = state == ST_TRAP;
    irq_no         = (state == ST_TRAP || state == ST_VECTOR) ? cause_q : '0;
    trap_epc       = (state == ST_TRAP || state == ST_VECTOR) ? epc_q : '0;
    redirect_valid = state == ST_VECTOR || state == ST_MRET;
    redirect_pc    = state == ST_VECTOR ? {mtvec[XLEN-1:2], 2'b00} :
                     state == ST_MRET   ? mepc : '0;
    stall          = state != ST_IDLE;
  end
endmodule
